// File: rtl/micro_div.sv
// micro_div: sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define MICRO_DIV_DBZ_EN to add the dbz port and a one-cycle divide-by-zero shortcut.
//
// state  | meaning
// IDLE   | waiting for start, result registers hold last result
// ITER   | one restoring step per clock, WIDTH_N steps
// DONE   | done strobe for one cycle, then back to IDLE
module micro_div #(
  parameter int WIDTH_N = 8,
  parameter int WIDTH_D = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder
`ifdef MICRO_DIV_DBZ_EN
  ,
  output logic               dbz
`endif
);

  localparam int CW = $clog2(WIDTH_N + 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH_N-1:0] n_q, n_d;
  logic [WIDTH_D-1:0] d_q, d_d;
  logic [WIDTH_D-1:0] p_q, p_d;
  logic [WIDTH_N-1:0] q_q, q_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH_N-1:0] quot_q, quot_d;
  logic [WIDTH_D-1:0] rem_q, rem_d;
`ifdef MICRO_DIV_DBZ_EN
  logic               dbz_q, dbz_d;
`endif

  // The trial value T is {t_hi, t_lo}. P < D keeps P within WIDTH_D bits, so the
  // subtract only needs the low WIDTH_D bits; t_hi=1 means T already exceeds any D.
  logic               t_hi;
  logic [WIDTH_D-1:0] t_lo;
  logic [WIDTH_D:0]   low_diff;
  logic               ge;
  logic [WIDTH_D-1:0] p_new;
  logic [WIDTH_N-1:0] q_new;

  always_comb begin
    t_hi     = p_q[WIDTH_D-1];
    t_lo     = {p_q[WIDTH_D-2:0], n_q[WIDTH_N-1]};
    low_diff = {1'b0, t_lo} - {1'b0, d_q};
    ge       = t_hi | ~low_diff[WIDTH_D];
    p_new    = ge ? low_diff[WIDTH_D-1:0] : t_lo;
    q_new    = {q_q[WIDTH_N-2:0], ge};

    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    p_d     = p_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef MICRO_DIV_DBZ_EN
    dbz_d   = dbz_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = dividend;
          d_d     = divisor;
          p_d     = '0;
          q_d     = '0;
          cnt_d   = CW'(WIDTH_N);
          state_d = S_ITER;
`ifdef MICRO_DIV_DBZ_EN
          dbz_d   = 1'b0;
          if (divisor == '0) begin
            state_d = S_DONE;
            quot_d  = '1;
            rem_d   = dividend[WIDTH_D-1:0];
            dbz_d   = 1'b1;
          end
`endif
        end
      end
      S_ITER: begin
        p_d   = p_new;
        q_d   = q_new;
        n_d   = n_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_d  = q_new;
          rem_d   = p_new;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      d_q     <= '0;
      p_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef MICRO_DIV_DBZ_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      p_q     <= p_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef MICRO_DIV_DBZ_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
`ifdef MICRO_DIV_DBZ_EN
  assign dbz       = dbz_q;
`endif

endmodule

// File: tb/tb_micro_div.sv
// Self-checking bench for micro_div: directed cases plus random operands against a plain
// arithmetic reference; follows MICRO_DIV_DBZ_EN when it is defined.
module tb_micro_div;

  localparam int WN = 8;
  localparam int WD = 4;

  logic          sys_clk;
  logic          sys_rst;
  logic          start;
  logic [WN-1:0] dividend;
  logic [WD-1:0] divisor;
  logic          busy;
  logic          done;
  logic [WN-1:0] quotient;
  logic [WD-1:0] remainder;
`ifdef MICRO_DIV_DBZ_EN
  logic          dbz;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [WN-1:0] last_q;
  logic [WD-1:0] last_r;

  micro_div #(.WIDTH_N(WN), .WIDTH_D(WD)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder)
`ifdef MICRO_DIV_DBZ_EN
    ,
    .dbz      (dbz)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk_fail(input string tag, input longint obs, input longint exp);
    n_fail++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void ref_div(input int a, input int b, output int q, output int r);
    if (b == 0) begin
      q = (1 << WN) - 1;
      r = a % (1 << WD);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic int exp_latency(input int b);
`ifdef MICRO_DIV_DBZ_EN
    return (b == 0) ? 1 : WN + 1;
`else
    return WN + 1;
`endif
  endfunction

  task automatic run_div(input int a, input int b);
    int q, r, lat, bcnt;
    bit got;
    ref_div(a, b, q, r);
    @(negedge sys_clk);
    dividend = WN'(a);
    divisor  = WD'(b);
    start    = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
    lat  = 0;
    bcnt = 0;
    got  = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge sys_clk);
      if (busy) bcnt++;
      if (done) begin
        got = 1;
        lat = i;
      end
    end
    n_assert++; if (got !== 1'b1) chk_fail("done_seen", got, 1);
    n_assert++; if (lat !== exp_latency(b)) chk_fail("latency", lat, exp_latency(b));
    n_assert++; if (bcnt !== exp_latency(b)) chk_fail("busy_cycles", bcnt, exp_latency(b));
    n_assert++; if (quotient !== WN'(q)) chk_fail("quotient", quotient, q);
    n_assert++; if (remainder !== WD'(r)) chk_fail("remainder", remainder, r);
`ifdef MICRO_DIV_DBZ_EN
    n_assert++; if (dbz !== (b == 0)) chk_fail("dbz", dbz, (b == 0));
`endif
    @(negedge sys_clk);
    n_assert++; if (busy !== 1'b0) chk_fail("idle_busy", busy, 0);
    n_assert++; if (done !== 1'b0) chk_fail("idle_done", done, 0);
    n_assert++; if (quotient !== WN'(q)) chk_fail("result_hold", quotient, q);
    last_q = WN'(q);
    last_r = WD'(r);
  endtask

  initial begin
    int q, r, dcnt, lat, prev_t;
    int ops_a[4];
    int ops_b[4];
    bit got;

    sys_rst  = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge sys_clk);
    n_assert++; if (busy !== 1'b0) chk_fail("rst_busy", busy, 0);
    n_assert++; if (done !== 1'b0) chk_fail("rst_done", done, 0);
    n_assert++; if (quotient !== '0) chk_fail("rst_quot", quotient, 0);
    n_assert++; if (remainder !== '0) chk_fail("rst_rem", remainder, 0);
`ifdef MICRO_DIV_DBZ_EN
    n_assert++; if (dbz !== 1'b0) chk_fail("rst_dbz", dbz, 0);
`endif
    sys_rst = 1'b0;
    @(negedge sys_clk);

    run_div(200, 7);
    run_div(255, 15);
    run_div(255, 1);
    run_div(9, 10);
    run_div(8'hA5, 0);
    run_div(13, 5);

    @(negedge sys_clk);
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
    dcnt = 0;
    lat  = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge sys_clk);
      if (i == 2) begin
        dividend = 8'd100;
        divisor  = 4'd3;
        start    = 1'b1;
      end
      if (i == 5) start = 1'b0;
      if (done) begin
        dcnt++;
        if (lat == 0) lat = i;
      end
    end
    n_assert++; if (dcnt !== 1) chk_fail("busy_start_dones", dcnt, 1);
    n_assert++; if (lat !== WN + 1) chk_fail("busy_start_lat", lat, WN + 1);
    n_assert++; if (quotient !== 8'd28) chk_fail("busy_start_quot", quotient, 28);
    n_assert++; if (remainder !== 4'd4) chk_fail("busy_start_rem", remainder, 4);
    run_div(100, 3);

    @(negedge sys_clk);
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
    repeat (4) @(negedge sys_clk);
    n_assert++; if (busy !== 1'b1) chk_fail("pre_rst_busy", busy, 1);
    sys_rst = 1'b1;
    #1;
    n_assert++; if (busy !== 1'b0) chk_fail("mid_rst_busy", busy, 0);
    n_assert++; if (done !== 1'b0) chk_fail("mid_rst_done", done, 0);
    n_assert++; if (quotient !== '0) chk_fail("mid_rst_quot", quotient, 0);
    n_assert++; if (remainder !== '0) chk_fail("mid_rst_rem", remainder, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    dcnt = 0;
    repeat (12) begin
      @(negedge sys_clk);
      if (done) dcnt++;
    end
    n_assert++; if (dcnt !== 0) chk_fail("rst_no_done", dcnt, 0);
    n_assert++; if (quotient !== '0) chk_fail("rst_quot_kept0", quotient, 0);
    run_div(50, 6);

    for (int k = 0; k < 20; k++)
      run_div(int'($urandom_range(255, 0)), int'($urandom_range(15, 0)));

    for (int k = 0; k < 4; k++) begin
      ops_a[k] = int'($urandom_range(255, 0));
      ops_b[k] = int'($urandom_range(15, 1));
    end
    @(negedge sys_clk);
    dividend = WN'(ops_a[0]);
    divisor  = WD'(ops_b[0]);
    start    = 1'b1;
    prev_t   = -1;
    for (int rnd = 0; rnd < 4; rnd++) begin
      got = 0;
      for (int i = 0; i < 30 && !got; i++) begin
        @(negedge sys_clk);
        if (done) got = 1;
        else begin
          n_assert++; if (quotient !== last_q) chk_fail("b2b_hold", quotient, last_q);
        end
      end
      n_assert++; if (got !== 1'b1) chk_fail("b2b_done_seen", got, 1);
      ref_div(ops_a[rnd], ops_b[rnd], q, r);
      n_assert++; if (quotient !== WN'(q)) chk_fail("b2b_quot", quotient, q);
      n_assert++; if (remainder !== WD'(r)) chk_fail("b2b_rem", remainder, r);
      if (prev_t >= 0) begin
        n_assert++; if ((cyc - prev_t) !== WN + 2) chk_fail("b2b_spacing", cyc - prev_t, WN + 2);
      end
      prev_t = cyc;
      last_q = WN'(q);
      last_r = WD'(r);
      if (rnd < 3) begin
        dividend = WN'(ops_a[rnd + 1]);
        divisor  = WD'(ops_b[rnd + 1]);
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge sys_clk);
    n_assert++; if (busy !== 1'b0) chk_fail("b2b_end_idle", busy, 0);
    n_assert++; if (remainder !== last_r) chk_fail("b2b_end_rem", remainder, last_r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
